ghost_enemy: RTL and testbench



---
 rtl/ghost_pkg.sv | 56 +++++
 rtl/ghost_tick_gen.sv | 34 +++
 rtl/ghost_enemy.sv | 177 +++++++++++++++++
 tb/tb_ghost_enemy.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// ghost_pkg: shared types and helpers for the ghost enemy blocks.
//   mode_t       : AI mode encodings (CHASE, FLEE, PATROL, HOLD)
//   dir_t        : horizontal direction (LEFT, RIGHT)
//   BG_COLOR_DEF : transparent sprite-ROM colour
//   sat_period   : tick period after speed reduction, floored at a minimum
//   step_axis    : one-axis step toward or away from a target
//   clamp_axis   : clamp a signed candidate position into [0, hi]
package ghost_pkg;

   typedef enum logic [1:0] {
      CHASE  = 2'd0,
      FLEE   = 2'd1,
      PATROL = 2'd2,
      HOLD   = 2'd3
   } mode_t;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } dir_t;

   localparam logic [11:0] BG_COLOR_DEF = 12'h6DE;

   // 27-bit arithmetic so the subtraction can never wrap below the floor.
   function automatic logic [26:0] sat_period(input int time_max, input int min_period,
                                              input logic [25:0] offset);
      logic [26:0] limit;
      limit = 27'(time_max - min_period);
      if ({1'b0, offset} <= limit) return 27'(time_max) - {1'b0, offset};
      else                         return 27'(min_period);
   endfunction

   // Result is signed and may leave the screen; the caller clamps it.
   function automatic logic signed [11:0] step_axis(input logic [9:0] pos, input logic [9:0] target,
                                                    input int step, input logic toward);
      logic signed [11:0] p;
      logic signed [11:0] t;
      logic signed [11:0] d;
      logic signed [11:0] s;
      p = $signed({2'b00, pos});
      t = $signed({2'b00, target});
      s = 12'(step);
      d = t - p;
      if (d == 12'sd0)        return p;
      else if (!toward)       return (d > 12'sd0) ? p - s : p + s;
      else if (d >= s || d <= -s) return (d > 12'sd0) ? p + s : p - s;
      else                    return t;
   endfunction

   function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input int hi);
      if (v < 12'sd0)          return 10'd0;
      else if (v > 12'(hi))    return 10'(hi);
      else                     return v[9:0];
   endfunction

endpackage

// File: rtl/ghost_tick_gen.sv
// ghost_tick_gen: movement tick generator shared by enemy blocks.
//   clk, reset   : clock, asynchronous active-high reset
//   speed_offset : reduction of the base period (floored at MIN_PERIOD)
//   freeze       : holds the counter and suppresses the tick
//   tick         : one-cycle pulse; the counter restarts on the same edge
module ghost_tick_gen
   import ghost_pkg::*;
#(
   parameter int TIME_MAX   = 4000000,
   parameter int MIN_PERIOD = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [25:0] speed_offset,
   input  logic        freeze,
   output logic        tick
);

   logic [26:0] period;
   logic [26:0] cnt;

   assign period = sat_period(TIME_MAX, MIN_PERIOD, speed_offset);
   // ">=" rather than "==" so a period shortened below the count ticks at once.
   assign tick   = !freeze && (cnt >= period - 27'd1);

   // Period counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       cnt <= 27'd0;
      else if (freeze) cnt <= cnt;
      else if (tick)   cnt <= 27'd0;
      else             cnt <= cnt + 27'd1;
   end

endmodule

// File: rtl/ghost_enemy.sv
// ghost_enemy: one ghost sprite - movement AI, screen clamp, facing,
// animation frame, sprite-ROM addressing and player collision.
//   clk, reset        : clock, asynchronous active-high reset
//   p_x, p_y          : player top-left position
//   x, y              : current VGA pixel
//   speed_offset      : score-dependent tick period reduction
//   mode              : 0 chase, 1 flee, 2 patrol, 3 hold
//   freeze            : stops movement timing
//   g_x, g_y          : ghost top-left position
//   rom_addr/rom_data : {row,col} sprite ROM, data one clk after address
//   ghost_on, rgb_out : opaque-pixel flag and colour, aligned with rom_data
//   collide           : registered bounding-box overlap with the player
module ghost_enemy
   import ghost_pkg::*;
#(
   parameter int          T_W         = 16,
   parameter int          MAX_X       = 640,
   parameter int          MAX_Y       = 480,
   parameter int          START_X     = 17,
   parameter int          START_Y     = 17,
   parameter int          STEP        = 1,
   parameter int          TIME_MAX    = 4000000,
   parameter int          MIN_PERIOD  = 100000,
   parameter int          FACE_PERIOD = 25000000,
   parameter int          PATROL_L    = 32,
   parameter int          PATROL_R    = 592,
   parameter logic [11:0] BG_COLOR    = BG_COLOR_DEF
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [9:0]                            p_x,
   input  logic [9:0]                            p_y,
   input  logic [9:0]                            x,
   input  logic [9:0]                            y,
   input  logic [25:0]                           speed_offset,
   input  logic [1:0]                            mode,
   input  logic                                  freeze,
   output logic [9:0]                            g_x,
   output logic [9:0]                            g_y,
   output logic [$clog2(4*T_W)+$clog2(T_W)-1:0]  rom_addr,
   input  logic [11:0]                           rom_data,
   output logic                                  ghost_on,
   output logic [11:0]                           rgb_out,
   output logic                                  collide
);

   localparam int ROW_W  = $clog2(4*T_W);
   localparam int COL_W  = $clog2(T_W);
   localparam int FACE_W = $clog2(FACE_PERIOD);
   localparam logic signed [11:0] PL = 12'(PATROL_L);
   localparam logic signed [11:0] PR = 12'(PATROL_R);
   localparam logic signed [11:0] SS = 12'(STEP);

   mode_t              mode_s;
   logic               tick;
   dir_t               facing;
   dir_t               patrol_dir;
   dir_t               dir_nxt;
   logic signed [11:0] gx_s;
   logic signed [11:0] nx;
   logic signed [11:0] ny;
   logic [FACE_W-1:0]  face_cnt;
   logic               frame;
   logic               in_box;
   logic               in_box_d;
   logic [COL_W-1:0]   dx;
   logic [COL_W-1:0]   dy;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [9:0]         adx;
   logic [9:0]         ady;

   assign mode_s = mode_t'(mode);
   assign gx_s   = $signed({2'b00, g_x});

   ghost_tick_gen #(
      .TIME_MAX   (TIME_MAX),
      .MIN_PERIOD (MIN_PERIOD)
   ) u_tick (
      .clk          (clk),
      .reset        (reset),
      .speed_offset (speed_offset),
      .freeze       (freeze),
      .tick         (tick)
   );

   // Candidate next position and patrol direction; applied only on a tick.
   always_comb begin
      nx      = gx_s;
      ny      = $signed({2'b00, g_y});
      dir_nxt = patrol_dir;
      if (tick) begin
         case (mode_s)
            CHASE: begin
               nx = step_axis(g_x, p_x, STEP, 1'b1);
               ny = step_axis(g_y, p_y, STEP, 1'b1);
            end
            FLEE: begin
               nx = step_axis(g_x, p_x, STEP, 1'b0);
               ny = step_axis(g_y, p_y, STEP, 1'b0);
            end
            PATROL: begin
               // Outside the range: walk back toward it before bouncing.
               if (gx_s < PL) begin
                  nx      = (gx_s + SS > PL) ? PL : gx_s + SS;
                  dir_nxt = RIGHT;
               end else if (gx_s > PR) begin
                  nx      = (gx_s - SS < PR) ? PR : gx_s - SS;
                  dir_nxt = LEFT;
               end else if (patrol_dir == RIGHT) begin
                  if (gx_s + SS >= PR) begin
                     nx      = PR;
                     dir_nxt = LEFT;
                  end else begin
                     nx = gx_s + SS;
                  end
               end else begin
                  if (gx_s - SS <= PL) begin
                     nx      = PL;
                     dir_nxt = RIGHT;
                  end else begin
                     nx = gx_s - SS;
                  end
               end
            end
            default: begin
               nx = gx_s;
            end
         endcase
      end else begin
         dir_nxt = patrol_dir;
      end
   end

   // Position, direction, facing, animation, pixel-pipeline and collision state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         g_x        <= 10'(START_X);
         g_y        <= 10'(START_Y);
         patrol_dir <= RIGHT;
         facing     <= RIGHT;
         face_cnt   <= '0;
         in_box_d   <= 1'b0;
         collide    <= 1'b0;
      end else begin
         g_x        <= clamp_axis(nx, MAX_X - T_W);
         g_y        <= clamp_axis(ny, MAX_Y - T_W);
         patrol_dir <= dir_nxt;
         if (mode_s == PATROL) facing <= dir_nxt;
         else if (p_x < g_x)   facing <= LEFT;
         else if (p_x > g_x)   facing <= RIGHT;
         else                  facing <= facing;
         face_cnt   <= (face_cnt == FACE_W'(FACE_PERIOD - 1)) ? '0 : face_cnt + FACE_W'(1);
         in_box_d   <= in_box;
         collide    <= (adx < 10'(T_W)) && (ady < 10'(T_W));
      end
   end

   assign frame  = (face_cnt >= FACE_W'(FACE_PERIOD / 2));
   // Only the low bits matter: they are used solely when the pixel is in the box.
   assign dx     = COL_W'(x - g_x);
   assign dy     = COL_W'(y - g_y);
   assign col    = (facing == RIGHT) ? dx : COL_W'(T_W - 1) - dx;
   assign row    = ROW_W'(dy) + (frame ? ROW_W'(T_W) : {ROW_W{1'b0}})
                 + ((mode_s == FLEE) ? ROW_W'(2*T_W) : {ROW_W{1'b0}});
   assign rom_addr = {row, col};

   assign in_box = (x >= g_x) && ({1'b0, x} < {1'b0, g_x} + 11'(T_W))
                && (y >= g_y) && ({1'b0, y} < {1'b0, g_y} + 11'(T_W));

   assign adx = (g_x > p_x) ? g_x - p_x : p_x - g_x;
   assign ady = (g_y > p_y) ? g_y - p_y : p_y - g_y;

   assign ghost_on = in_box_d && (rom_data != BG_COLOR);
   assign rgb_out  = rom_data;

endmodule

// File: tb/tb_ghost_enemy.sv
module tb_ghost_enemy;
   import ghost_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  p_x, p_y, x, y;
   logic [25:0] speed_offset;
   logic [1:0]  mode;
   logic        freeze;
   logic [11:0] rom_data;
   logic [9:0]  g_x, g_y, g_x2, g_y2;
   logic [9:0]  rom_addr, rom_addr2;
   logic        ghost_on, ghost_on2, collide, collide2;
   logic [11:0] rgb_out, rgb_out2;

   int nchecks = 0;
   int nerrors = 0;

   always #5 clk = ~clk;

   ghost_enemy #(.T_W(16), .STEP(1), .TIME_MAX(20), .MIN_PERIOD(4), .FACE_PERIOD(1000000)) dut (
      .clk(clk), .reset(reset), .p_x(p_x), .p_y(p_y), .x(x), .y(y),
      .speed_offset(speed_offset), .mode(mode), .freeze(freeze),
      .g_x(g_x), .g_y(g_y), .rom_addr(rom_addr), .rom_data(rom_data),
      .ghost_on(ghost_on), .rgb_out(rgb_out), .collide(collide));

   ghost_enemy #(.T_W(16), .STEP(4), .TIME_MAX(20), .MIN_PERIOD(4), .FACE_PERIOD(8)) dut2 (
      .clk(clk), .reset(reset), .p_x(p_x), .p_y(p_y), .x(x), .y(y),
      .speed_offset(speed_offset), .mode(mode), .freeze(freeze),
      .g_x(g_x2), .g_y(g_y2), .rom_addr(rom_addr2), .rom_data(rom_data),
      .ghost_on(ghost_on2), .rgb_out(rgb_out2), .collide(collide2));

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rom;
      logic        chk_addr;
      logic [9:0]  addr;
      logic        on;
   } pix_vec_t;

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       col;
   } col_vec_t;

   typedef struct {
      logic        on;
      logic [11:0] rgb;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset held across two edges, released at a falling edge.
   task automatic do_reset();
      reset = 1'b1;
      wait_edges(2);
      reset = 1'b0;
   endtask

   initial begin
      pix_vec_t pv[8];
      col_vec_t cv[6];
      exp_t     e;

      // Ghost at (200,200), facing LEFT, frame 0, HOLD.
      pv[0] = '{10'd205, 10'd203, 12'h6DE, 1'b1, 10'd58,  1'b0};
      pv[1] = '{10'd205, 10'd203, 12'hF00, 1'b1, 10'd58,  1'b1};
      pv[2] = '{10'd200, 10'd200, 12'h123, 1'b1, 10'd15,  1'b1};
      pv[3] = '{10'd215, 10'd215, 12'h0AB, 1'b1, 10'd240, 1'b1};
      pv[4] = '{10'd216, 10'd200, 12'h123, 1'b0, 10'd0,   1'b0};
      pv[5] = '{10'd199, 10'd205, 12'h123, 1'b0, 10'd0,   1'b0};
      pv[6] = '{10'd210, 10'd216, 12'h123, 1'b0, 10'd0,   1'b0};
      pv[7] = '{10'd210, 10'd199, 12'h6DE, 1'b0, 10'd0,   1'b0};

      cv[0] = '{10'd215, 10'd185, 1'b1};
      cv[1] = '{10'd215, 10'd184, 1'b0};
      cv[2] = '{10'd216, 10'd200, 1'b0};
      cv[3] = '{10'd185, 10'd215, 1'b1};
      cv[4] = '{10'd184, 10'd200, 1'b0};
      cv[5] = '{10'd200, 10'd200, 1'b1};

      reset = 1'b1; p_x = 10'd100; p_y = 10'd17; x = 10'd0; y = 10'd0;
      speed_offset = 26'd16; mode = CHASE; freeze = 1'b0; rom_data = 12'h000;
      wait_edges(2);
      check("reset_gx", 32'(g_x), 32'd17);
      check("reset_gy", 32'(g_y), 32'd17);
      check("reset_collide", 32'(collide), 32'd0);
      check("reset_ghost_on", 32'(ghost_on), 32'd0);
      check("reset_gx2", 32'(g_x2), 32'd17);
      check("reset_collide2", 32'(collide2), 32'd0);
      check("reset_ghost_on2", 32'(ghost_on2), 32'd0);

      // CHASE at P=4 toward (100,17).
      reset = 1'b0;
      for (int k = 1; k <= 83; k++) begin
         wait_edges(3);
         check("chase_hold", 32'(g_x), 32'(17 + k - 1));
         wait_edges(1);
         check("chase_step", 32'(g_x), 32'(17 + k));
      end
      wait_edges(8);
      check("chase_stop_x", 32'(g_x), 32'd100);
      check("chase_stop_y", 32'(g_y), 32'd17);
      check("chase_collide", 32'(collide), 32'd1);

      // Period shortened at count 15, then freeze.
      speed_offset = 26'd0;
      do_reset();
      wait_edges(15);
      check("speed_pre", 32'(g_x), 32'd17);
      speed_offset = 26'd10;
      wait_edges(1);
      check("speed_immediate_tick", 32'(g_x), 32'd18);
      wait_edges(9);
      check("speed_p10_hold", 32'(g_x), 32'd18);
      wait_edges(1);
      check("speed_p10_tick", 32'(g_x), 32'd19);
      freeze = 1'b1;
      wait_edges(50);
      check("freeze_hold", 32'(g_x), 32'd19);
      freeze = 1'b0;
      wait_edges(9);
      check("unfreeze_hold", 32'(g_x), 32'd19);
      wait_edges(1);
      check("unfreeze_tick", 32'(g_x), 32'd20);

      // FLEE from (5,5) with player at (10,10).
      speed_offset = 26'd16; p_x = 10'd5; p_y = 10'd5;
      do_reset();
      wait_edges(48);
      check("flee_start_x", 32'(g_x), 32'd5);
      check("flee_start_y", 32'(g_y), 32'd5);
      mode = FLEE; p_x = 10'd10; p_y = 10'd10;
      wait_edges(4);
      check("flee_step_x", 32'(g_x), 32'd4);
      check("flee_step_y", 32'(g_y), 32'd4);
      wait_edges(24);
      check("flee_clamp_x", 32'(g_x), 32'd0);
      check("flee_clamp_y", 32'(g_y), 32'd0);
      x = 10'd0; y = 10'd0; #1;
      check("flee_rom_addr", 32'(rom_addr), 32'd512);
      check("flee_collide", 32'(collide), 32'd1);

      // PATROL on the STEP=4 instance from x=590.
      mode = CHASE; p_x = 10'd590; p_y = 10'd17;
      do_reset();
      wait_edges(576);
      check("patrol_entry_x", 32'(g_x2), 32'd590);
      check("patrol_entry_y", 32'(g_y2), 32'd17);
      mode = PATROL;
      wait_edges(4);
      check("patrol_clamp_r", 32'(g_x2), 32'd592);
      x = 10'd595; y = 10'd17; #1;
      check("patrol_facing_left", 32'(rom_addr2), 32'd268);
      wait_edges(4);
      check("patrol_turn", 32'(g_x2), 32'd588);
      x = 10'd591; #1;
      check("patrol_facing_left2", 32'(rom_addr2), 32'd12);
      check("patrol_y_held", 32'(g_y2), 32'd17);

      // Park the ghost at (200,200) for the pixel and collision tables.
      mode = CHASE; p_x = 10'd200; p_y = 10'd200;
      do_reset();
      wait_edges(732);
      check("park_x", 32'(g_x), 32'd200);
      check("park_y", 32'(g_y), 32'd200);
      mode = HOLD; p_x = 10'd150; p_y = 10'd200;
      wait_edges(2);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         x = pv[i].x; y = pv[i].y; #1;
         if (pv[i].chk_addr) check("pix_rom_addr", 32'(rom_addr), 32'(pv[i].addr));
         sb.push_back('{on: pv[i].on, rgb: pv[i].rom});
         @(posedge clk);
         #1 rom_data = pv[i].rom;
         #1;
         if (sb.size() == 0) begin
            check("pix_scoreboard_empty", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pix_ghost_on", 32'(ghost_on), 32'(e.on));
            check("pix_rgb_out", 32'(rgb_out), 32'(e.rgb));
         end
      end

      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         p_x = cv[i].px; p_y = cv[i].py;
         wait_edges(1);
         check("collide_box", 32'(collide), 32'(cv[i].col));
      end

      // Reset mid-move clears state without waiting for a clock edge.
      mode = CHASE; p_x = 10'd205; p_y = 10'd205;
      wait_edges(6);
      check("pre_reset_collide", 32'(collide), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_gx", 32'(g_x), 32'd17);
      check("async_reset_gy", 32'(g_y), 32'd17);
      check("async_reset_collide", 32'(collide), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_edges(3);
      check("post_reset_hold", 32'(g_x), 32'd17);
      wait_edges(1);
      check("post_reset_tick_x", 32'(g_x), 32'd18);
      check("post_reset_tick_y", 32'(g_y), 32'd18);

      // Animation frame on the FACE_PERIOD=8 instance.
      mode = HOLD; p_x = 10'd17; p_y = 10'd17; x = 10'd17; y = 10'd17; rom_data = 12'h0F0;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         #1;
         check("frame_rom_addr", 32'(rom_addr2), ((k % 8) >= 4) ? 32'd256 : 32'd0);
         if (k == 1) begin
            check("frame_ghost_on", 32'(ghost_on2), 32'd1);
            check("frame_rgb_out", 32'(rgb_out2), 32'h0F0);
         end
         wait_edges(1);
      end

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

endmodule
